// File: rtl/serial_word_loader_pkg.sv
// Shared types and constants for the serial word loader.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } loader_state_t;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/serial_word_loader_bit_counter.sv
// Up-counter of received bits: sync clear, increment enable, terminal flag at WIDTH-1.
module bit_counter #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rset,
  input  logic                   clr,
  input  logic                   inc,
  output logic [$clog2(WIDTH):0] cnt,
  output logic                   term
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear takes priority so a restart never counts the bit of the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_word_loader.sv
// Assembles a WIDTH-bit word from a framed serial stream and strobes it into a register.
// Handshake: each bit_valid=1 cycle in SHIFT consumes bit_in; en is a one-cycle load with d valid alongside.
module serial_word_loader
  import loader_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rset,
  input  logic                   start,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  input  logic                   abort,
  output logic [WIDTH-1:0]       d,
  output logic                   en,
  output logic                   busy,
  output logic                   frame_err,
  output logic [$clog2(WIDTH):0] bit_cnt
);

  loader_state_t    state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
  logic [WIDTH-1:0] shifted;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_term;

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk  (clk),
    .rset (rset),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (bit_cnt),
    .term (cnt_term)
  );

  always_comb begin
    if (MSB_FIRST) begin
      shifted = {sreg_q[WIDTH-2:0], bit_in};
    end else begin
      shifted = {bit_in, sreg_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    d_d         = d_q;
    frame_err_d = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          sreg_d  = '0;
          cnt_clr = 1'b1;
        end
      end
      SHIFT: begin
        // abort beats start; start restarts the frame and drops any bit of that cycle
        if (abort) begin
          state_d = IDLE;
          sreg_d  = '0;
          cnt_clr = 1'b1;
        end else if (start) begin
          sreg_d      = '0;
          cnt_clr     = 1'b1;
          frame_err_d = 1'b1;
        end else if (bit_valid) begin
          sreg_d  = shifted;
          cnt_inc = 1'b1;
          if (cnt_term) begin
            state_d = LOAD;
            d_d     = shifted;
          end
        end
      end
      LOAD: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
    en_d   = (state_d == LOAD);
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rset) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      d_q         <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      d_q         <= d_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign d         = d_q;
  assign en        = en_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule
